// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the fetch stage (reads only) and the
// load/store unit (reads and writes). At most one request is granted per
// cycle. Data accesses normally win. Fetch is forced through once it has been
// denied MAX_STALL consecutive cycles. Each read response is routed back to its
// owner exactly one cycle after the grant.
//
// Handshake: a requester raises *_req_i and holds it, together with its
// address and data, until it sees *_gnt_o high. The gnt output is
// combinational and is asserted in the same cycle as the request. A transfer
// takes place in every cycle where req and gnt are both high.
// *_rvalid_o is a single-cycle pulse with no back-pressure: the requester must
// take *_rdata_o in that cycle.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   if_req_i/addr_i  fetch read request and address; if_flush_i drops the
//                    in-flight fetch response and blocks a fetch grant
//   if_gnt_o         fetch accepted; if_rvalid_o/if_rdata_o carry the
//                    instruction word
//   ls_req_i/we_i/addr_i/wdata_i
//                    load/store request
//   ls_gnt_o         load/store accepted; ls_rvalid_o/ls_rdata_o carry the
//                    load data
//   mem_addr_o/data_o/read_en_o/write_en_o
//                    memory command, zero when nothing is granted
//   mem_data_i       memory read data, valid one cycle after mem_read_en_o
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [AWIDTH-1:0] ls_addr_i,
    input  logic [DWIDTH-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DWIDTH-1:0] ls_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    localparam int            CW        = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] STALL_MAX = CW'(MAX_STALL);

    // Owner of the read response that arrives in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    owner_t        owner_q, owner_d;
    logic [CW-1:0] starve_cnt, starve_d;
    logic          flush_hit, if_elig, starved, if_gnt, ls_gnt;

    // Grant decision. A flush only matters while a fetch response is in
    // flight. It then also blocks a new fetch, because that fetch belongs to
    // the discarded stream. Nothing is granted while reset is held.
    always_comb begin
        flush_hit = if_flush_i && (owner_q == OWN_IF);
        if_elig   = rst && if_req_i && !flush_hit;
        starved   = (starve_cnt == STALL_MAX);
        ls_gnt    = rst && ls_req_i && !(if_elig && starved);
        if_gnt    = if_elig && !ls_gnt;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q    <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            owner_q    <= owner_d;
            starve_cnt <= starve_d;
        end
    end

    // Next state
    always_comb begin
        starve_d = starve_cnt;
        owner_d  = OWN_NONE;
        // The starvation count runs only while fetch is waiting and data wins.
        // If fetch is blocked by a flush and nobody wins, the count holds.
        if (if_gnt || !if_req_i) begin
            starve_d = '0;
        end else if (ls_gnt && !starved) begin
            starve_d = starve_cnt + 1'b1;
        end
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (ls_gnt && !ls_we_i) begin
            owner_d = OWN_LS;
        end
    end

    // Outputs
    always_comb begin
        if_gnt_o       = if_gnt;
        ls_gnt_o       = ls_gnt;
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (if_gnt) begin
            mem_addr_o    = if_addr_i;
            mem_read_en_o = 1'b1;
        end else if (ls_gnt) begin
            mem_addr_o     = ls_addr_i;
            mem_data_o     = ls_wdata_i;
            mem_read_en_o  = !ls_we_i;
            mem_write_en_o = ls_we_i;
        end
        if_rvalid_o = (owner_q == OWN_IF) && !if_flush_i;
        if_rdata_o  = if_rvalid_o ? mem_data_i : '0;
        ls_rvalid_o = (owner_q == OWN_LS);
        ls_rdata_o  = ls_rvalid_o ? mem_data_i : '0;
    end

endmodule
